// File: rtl/jk_cmd_driver.sv
`default_nettype none
// ============================================================================
//  Module   : jk_cmd_driver
//  Purpose  : Command front end for a jk_ff. It buffers set/clear/toggle/hold
//             commands in a small FIFO and drives j/k for one clock per
//             command. It also keeps a shadow copy of the expected q and
//             checks the flop's q feedback in the cycle after each drive.
//  Revision : 1.0  initial release
// ============================================================================
module jk_cmd_driver #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd,
   input  logic             q_fb,
   output logic             j,
   output logic             k,
   output logic             exp_q,
   output logic             busy,
   output logic             done,
   output logic             mismatch,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int             c_ptr_w = $clog2(DEPTH);
   localparam logic [c_ptr_w:0] c_full = (c_ptr_w+1)'(DEPTH);

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_drive = 2'd1;
   localparam logic [1:0] c_check = 2'd2;

   // FIFO storage and bookkeeping
   logic [1:0]         mem_q [DEPTH];
   logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
   logic [c_ptr_w:0]   count_q, count_d;

   // FSM and output registers
   logic [1:0]       state_q, state_d;
   logic             j_q, j_d;
   logic             k_q, k_d;
   logic             shadow_q, shadow_d;
   logic             mismatch_q, mismatch_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic       fifo_nempty;
   logic       push;
   logic       pop;
   logic [1:0] head;

   // Ready is derived from the registered count alone, so a pop in the same
   // cycle never opens a slot for a push while the FIFO is full.
   assign cmd_ready   = (count_q != c_full);
   assign fifo_nempty = (count_q != '0);
   assign push        = cmd_valid && cmd_ready;
   assign pop         = fifo_nempty && ((state_q == c_idle) || (state_q == c_check));
   assign head        = mem_q[rd_ptr_q];

   assign j        = j_q;
   assign k        = k_q;
   assign exp_q    = shadow_q;
   assign mismatch = mismatch_q;
   assign err_cnt  = err_cnt_q;
   assign done     = (state_q == c_check);
   assign busy     = fifo_nempty || (state_q != c_idle);

   // FIFO pointer and occupancy update
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
      if (push && !pop) begin
         count_d = count_q + (c_ptr_w+1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (c_ptr_w+1)'(1);
      end
   end

   // FIFO storage write; contents need no reset since pointers gate reads
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= cmd;
   end

   // Next-state logic: IDLE -> DRIVE -> CHECK -> (DRIVE | IDLE)
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_idle:  if (fifo_nempty) state_d = c_drive;
         c_drive: state_d = c_check;
         c_check: state_d = fifo_nempty ? c_drive : c_idle;
         default: state_d = c_idle;
      endcase
   end

   // Output/datapath logic: j/k launch, shadow q update, feedback check
   always_comb begin
      j_d        = 1'b0;
      k_d        = 1'b0;
      shadow_d   = shadow_q;
      mismatch_d = mismatch_q;
      err_cnt_d  = err_cnt_q;
      // j/k carry a code only for the cycle after a pop, i.e. in DRIVE
      if (pop) begin
         j_d = head[1];
         k_d = head[0];
      end
      // Shadow follows the flop on the same edge that closes DRIVE
      if (state_q == c_drive) begin
         case ({j_q, k_q})
            2'b01:   shadow_d = 1'b0;
            2'b10:   shadow_d = 1'b1;
            2'b11:   shadow_d = ~shadow_q;
            default: shadow_d = shadow_q;
         endcase
      end
      if ((state_q == c_check) && (q_fb != shadow_q)) begin
         mismatch_d = 1'b1;
         if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   // State register with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= c_idle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         j_q        <= 1'b0;
         k_q        <= 1'b0;
         shadow_q   <= 1'b0;
         mismatch_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         j_q        <= j_d;
         k_q        <= k_d;
         shadow_q   <= shadow_d;
         mismatch_q <= mismatch_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_jk_cmd_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jk_cmd_driver
//  Purpose  : Self-checking bench for jk_cmd_driver with a jk_ff model on the
//             feedback path and a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jk_cmd_driver;

   localparam int DEPTH   = 4;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       cmd = 2'b00;
   logic             q_fb;
   logic             j, k, exp_q, busy, done, mismatch;
   logic [CNT_W-1:0] err_cnt;

   int checks   = 0;
   int failures = 0;

   jk_cmd_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd(cmd), .q_fb(q_fb), .j(j), .k(k), .exp_q(exp_q), .busy(busy),
      .done(done), .mismatch(mismatch), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // Driven jk_ff, reset by the same system reset; inject corrupts feedback only
   logic q_ff;
   logic inject = 1'b0;
   assign q_fb = q_ff ^ inject;

   always @(posedge clk or negedge rst) begin
      if (!rst) q_ff <= 1'b0;
      else case ({j, k})
         2'b01:   q_ff <= 1'b0;
         2'b10:   q_ff <= 1'b1;
         2'b11:   q_ff <= ~q_ff;
         default: q_ff <= q_ff;
      endcase
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
      end
   endfunction

   // Reference model: command queue plus the phase of the command in flight
   logic [1:0] m_fifo [$];
   int         m_phase;   // 0 nothing in flight, 1 driving, 2 checking
   logic [1:0] m_code;
   logic       m_exp, m_mis;
   int         m_cnt;
   bit         m_acc, m_nonempty;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_fifo.delete();
         m_phase = 0; m_code = 2'b00; m_exp = 1'b0; m_mis = 1'b0; m_cnt = 0;
      end else begin
         m_acc      = cmd_valid && (m_fifo.size() < DEPTH);
         m_nonempty = (m_fifo.size() > 0);
         if (m_phase == 1) begin
            if (m_code == 2'b01) m_exp = 1'b0;
            else if (m_code == 2'b10) m_exp = 1'b1;
            else if (m_code == 2'b11) m_exp = ~m_exp;
            m_phase = 2;
         end else begin
            if (m_phase == 2 && q_fb !== m_exp) begin
               m_mis = 1'b1;
               if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            end
            if (m_nonempty) begin
               m_code  = m_fifo.pop_front();
               m_phase = 1;
            end else begin
               m_phase = 0;
            end
         end
         if (m_acc) m_fifo.push_back(cmd);
      end
   end

   // Per-cycle compare against the model plus observation logs
   logic [1:0] log_jk [$];
   logic       log_exp [$];
   logic       log_qfb [$];
   logic [1:0] prev_jk = 2'b00;
   logic       rdy_s = 1'b1;
   bit         saw_not_ready = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         chk("cmd_ready", 32'(cmd_ready), 32'(m_fifo.size() < DEPTH));
         chk("jk", 32'({j, k}), 32'((m_phase == 1) ? m_code : 2'b00));
         chk("exp_q", 32'(exp_q), 32'(m_exp));
         chk("busy", 32'(busy), 32'((m_fifo.size() > 0) || (m_phase != 0)));
         chk("done", 32'(done), 32'(m_phase == 2));
         chk("mismatch", 32'(mismatch), 32'(m_mis));
         chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
         if (done) begin
            log_jk.push_back(prev_jk);
            log_exp.push_back(exp_q);
            log_qfb.push_back(q_fb);
         end
         if (!cmd_ready) saw_not_ready = 1'b1;
         prev_jk = {j, k};
         rdy_s   = cmd_ready;
      end
   end

   task automatic clear_logs();
      log_jk.delete(); log_exp.delete(); log_qfb.delete();
      saw_not_ready = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_jk"}, 32'({j, k}), 32'h0);
      chk({tag, "_exp_q"}, 32'(exp_q), 32'h0);
      chk({tag, "_done"}, 32'(done), 32'h0);
      chk({tag, "_mismatch"}, 32'(mismatch), 32'h0);
      chk({tag, "_err_cnt"}, 32'(err_cnt), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
   endtask

   task automatic do_reset();
      cmd_valid = 1'b0; inject = 1'b0;
      rst = 1'b0;
      #1;
      chk_idle_outputs("rst");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      clear_logs();
   endtask

   // Present one command and hold it until the DUT accepts it
   task automatic push(input logic [1:0] c);
      bit ok;
      ok = 1'b0;
      cmd_valid = 1'b1; cmd = c;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("push_timeout", 32'h0, 32'h1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      cmd_valid = 1'b0;
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         if (!busy) begin ok = 1'b1; break; end
      end
      if (!ok) chk("idle_timeout", 32'h0, 32'h1);
      @(posedge clk); #1;
   endtask

   logic [1:0] t1_jk  [4] = '{2'b10, 2'b00, 2'b11, 2'b01};
   logic       t1_exp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
   logic [1:0] t2_cmd [8] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10, 2'b01, 2'b11};
   logic       t6_exp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      bit found;
      #2;
      do_reset();

      // Back-to-back set, hold, toggle, clear
      foreach (t1_jk[i]) push(t1_jk[i]);
      wait_idle();
      chk("t1_dones", 32'(log_jk.size()), 32'd4);
      if (log_jk.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("t1_jk_seq", 32'(log_jk[i]), 32'(t1_jk[i]));
            chk("t1_exp_seq", 32'(log_exp[i]), 32'(t1_exp[i]));
            chk("t1_qfb_seq", 32'(log_qfb[i]), 32'(t1_exp[i]));
         end
      end
      chk("t1_mismatch", 32'(mismatch), 32'h0);
      chk("t1_err_cnt", 32'(err_cnt), 32'h0);

      // Overfill with valid held high: back-pressure, order preserved
      do_reset();
      foreach (t2_cmd[i]) push(t2_cmd[i]);
      wait_idle();
      chk("t2_backpressure", 32'(saw_not_ready), 32'h1);
      chk("t2_dones", 32'(log_jk.size()), 32'd8);
      if (log_jk.size() == 8) begin
         for (int i = 0; i < 8; i++) chk("t2_order", 32'(log_jk[i]), 32'(t2_cmd[i]));
      end

      // Forced mismatch on a set, then a clean command
      do_reset();
      inject = 1'b1;
      push(2'b10);
      wait_idle();
      inject = 1'b0;
      chk("t3_mismatch", 32'(mismatch), 32'h1);
      chk("t3_err_cnt", 32'(err_cnt), 32'd1);
      push(2'b00);
      wait_idle();
      chk("t3_sticky", 32'(mismatch), 32'h1);
      chk("t3_err_hold", 32'(err_cnt), 32'd1);

      // Counter saturation
      do_reset();
      inject = 1'b1;
      for (int i = 0; i < 300; i++) push(2'($urandom_range(0, 3)));
      wait_idle();
      inject = 1'b0;
      chk("t4_saturate", 32'(err_cnt), 32'd255);
      chk("t4_mismatch", 32'(mismatch), 32'h1);

      // Reset during DRIVE with three entries queued
      do_reset();
      found = 1'b0;
      cmd_valid = 1'b1; cmd = 2'b10;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (m_phase == 1 && m_fifo.size() == 3) begin found = 1'b1; break; end
      end
      chk("t5_reach_drive", 32'(found), 32'h1);
      #2;
      cmd_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk_idle_outputs("t5_async");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         chk("t5_no_jk", 32'({j, k}), 32'h0);
         chk("t5_ready", 32'(cmd_ready), 32'h1);
      end
      @(posedge clk); #1;

      // Five toggles from reset
      do_reset();
      for (int i = 0; i < 5; i++) push(2'b11);
      wait_idle();
      chk("t6_dones", 32'(log_exp.size()), 32'd5);
      if (log_exp.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            chk("t6_exp_seq", 32'(log_exp[i]), 32'(t6_exp[i]));
            chk("t6_qfb_seq", 32'(log_qfb[i]), 32'(t6_exp[i]));
         end
      end

      // Randomized traffic with occasional feedback corruption
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if (!(cmd_valid && !rdy_s)) begin
            cmd_valid = ($urandom_range(0, 9) < 6);
            cmd       = 2'($urandom_range(0, 3));
         end
         inject = ($urandom_range(0, 9) == 0);
         @(posedge clk); #1;
      end
      inject = 1'b0;
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
